// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the inter-stage buffers and their benches.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_buf_state_t;

  localparam int unsigned PIPE_BUF_DEPTH = 2;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stage link: master drives valid/ctrl/data, slave returns ready.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);

endinterface

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter for stage performance monitors.
// Only compiled when PIPE_STAGE_PERF_EN is defined.
`ifdef PIPE_STAGE_PERF_EN
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with 2-entry skid storage and synchronous flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_buf
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  pipe_stage_buf_if.slave   in_if,
  pipe_stage_buf_if.master  out_if,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_buf_state_t   state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic out_valid;
  logic in_fire;
  logic out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_if.valid & in_ready_q;
  assign out_fire  = out_valid & out_if.ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Payload is held on purpose; only control bits are squashed.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_if.ctrl;
            main_data_d = in_if.data;
          end else if (in_fire) begin
            state_d     = TWO;
            skid_ctrl_d = in_if.ctrl;
            skid_data_d = in_if.data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Ready is registered from next state so downstream ready never reaches upstream combinationally.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid;
  assign out_if.ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_if.data  = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = out_valid & ~out_if.ready;
  assign bubble_inc = ~out_valid & ~flush;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed bench for pipe_stage_buf against a queue-based reference model.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned CNT_MAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          CLK;
  logic          nRST;
  logic          flush;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;

  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) in_if ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) out_if ();

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .flush      (flush),
    .in_if      (in_if),
    .out_if     (out_if),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  // Reference: a 2-deep FIFO plus plain event counts.
  entry_t      q[$];
  int unsigned m_stall  = 0;
  int unsigned m_bubble = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      int unsigned n;
      entry_t      e;
      n = q.size();
      if (n > 0 && !out_if.ready && m_stall < CNT_MAX) m_stall++;
      if (n == 0 && !flush && m_bubble < CNT_MAX) m_bubble++;
      if (flush) begin
        q.delete();
      end else begin
        if (n > 0 && out_if.ready) void'(q.pop_front());
        if (in_if.valid && n < 2) begin
          e.ctrl = in_if.ctrl;
          e.data = in_if.data;
          q.push_back(e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_if.ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_if.valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_ctrl", 64'(out_if.ctrl), 64'(q[0].ctrl));
      check("out_data", 64'(out_if.data), 64'(q[0].data));
    end else begin
      check("out_ctrl_idle", 64'(out_if.ctrl), 64'd0);
    end
    check("stall_cnt", 64'(stall_cnt), PERF_EN ? 64'(m_stall) : 64'd0);
    check("bubble_cnt", 64'(bubble_cnt), PERF_EN ? 64'(m_bubble) : 64'd0);
  endtask

  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
    @(negedge CLK);
    in_if.valid   = v;
    in_if.ctrl    = c;
    in_if.data    = d;
    out_if.ready  = ordy;
    flush         = fl;
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_out_ctrl", 64'(out_if.ctrl), 64'd0);
    check("rst_in_ready", 64'(in_if.ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    flush        = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST         = 1'b0;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.ctrl   = '0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    q.delete();
    repeat (2) @(negedge CLK);
    #1;
    check("init_out_data", 64'(out_if.data), 64'd0);
    check("init_out_valid", 64'(out_if.valid), 64'd0);
    check("init_in_ready", 64'(in_if.ready), 64'd1);
    nRST = 1'b1;

    // Reset asserted with a transfer in flight.
    step(1'b1, 8'h55, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b1, 8'h66, 32'h9abc_def0, 1'b0, 1'b0);
    do_reset();

    // Streaming at full rate.
    for (int unsigned i = 1; i <= 16; i++)
      step(1'b1, CW'(i), $urandom, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Back-pressure: A then B held, then released.
    step(1'b1, 8'h0A, 32'hA, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 32'hB, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 8'h0C, 32'hC, 1'b0, 1'b0);
    check("bp_in_ready_low", 64'(in_if.ready), 64'd0);
    check("bp_hold_a", 64'(out_if.data), 64'hA);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("bp_release_a", 64'(out_if.data), 64'hA);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("bp_release_b", 64'(out_if.data), 64'hB);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while full, with C offered in the same cycle.
    step(1'b1, 8'h11, 32'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 32'h22, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 32'hC, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("flush_out_valid", 64'(out_if.valid), 64'd0);
    check("flush_out_ctrl", 64'(out_if.ctrl), 64'd0);
    check("flush_in_ready", 64'(in_if.ready), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Simultaneous in/out fire while holding one entry.
    step(1'b1, 8'h31, 32'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 32'h32, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("simul_new_entry", 64'(out_if.data), 64'h32);
    check("simul_in_ready", 64'(in_if.ready), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Long stall drives the 4-bit stall counter into saturation.
    do_reset();
    step(1'b1, 8'h44, 32'h44, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("stall_saturated", 64'(stall_cnt), PERF_EN ? 64'hF : 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int unsigned i = 0; i < 400; i++)
      step(1'($urandom), CW'($urandom), $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
